// File: rtl/set_pkg.sv
// set_pkg: shared job record, SET mode codes and dispatcher FSM states
package set_pkg;

    typedef struct packed {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
    } set_job_t;

    localparam logic [1:0] MODE_A     = 2'b00;
    localparam logic [1:0] MODE_UNION = 2'b01;
    localparam logic [1:0] MODE_DIFF  = 2'b10;
    localparam logic [1:0] MODE_INTER = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_VALID,
        S_RESULT
    } set_state_t;

endpackage

// File: rtl/set_job_fifo.sv
// set_job_fifo: synchronous FIFO of SET jobs; full pushes are refused, no bypass
module set_job_fifo
    import set_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  set_job_t i_data,
    input  logic     i_pop,
    output set_job_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    set_job_t      r_mem [DEPTH];
    logic          w_wr;
    logic          w_rd;

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // pointers wrap by natural overflow since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    // storage is qualified by the count, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/set_job_dispatcher.sv
// set_job_dispatcher: feeds buffered jobs to SET one at a time and returns tagged counts
// Optional watchdog on the SET response enabled by defining SET_WDOG_EN.
module set_job_dispatcher
    import set_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 6,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_central,
    input  logic [11:0]      in_radius,
    input  logic [1:0]       in_mode,
    output logic             set_en,
    output logic [23:0]      set_central,
    output logic [11:0]      set_radius,
    output logic [1:0]       set_mode,
    input  logic             set_busy,
    input  logic             set_valid,
    input  logic [7:0]       set_candidate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_candidate,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             stray_valid
);

    set_state_t       r_state;
    set_state_t       w_state_nxt;
    set_job_t         w_in_job;
    set_job_t         w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_timeout;
    logic             w_done;
    logic [TAG_W-1:0] r_issue_tag;
    logic             r_set_en;
    set_job_t         r_job;
    logic             r_res_valid;
    logic [7:0]       r_res_candidate;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;
    logic             r_stray;

    assign w_in_job = '{central: in_central, radius: in_radius, mode: in_mode};
    assign w_done   = (r_state == S_WAIT_VALID) && (set_valid || w_timeout);

    set_job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (w_in_job),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef SET_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] r_wdog;

    assign w_timeout = (r_state == S_WAIT_VALID) && (r_wdog == WW'(WDOG_CYCLES - 1));

    // cycles spent waiting on SET, restarted by every issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_wdog <= '0;
        else if (r_state == S_ISSUE) r_wdog <= '0;
        else if (r_state == S_WAIT_VALID) r_wdog <= r_wdog + WW'(1);
    end
`else
    assign w_timeout = 1'b0 && (WDOG_CYCLES > 0);
`endif

    // next state and FIFO pop; the pop happens on the edge that enters ISSUE
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop       = !w_empty && !set_busy;
                w_state_nxt = w_pop ? S_ISSUE : S_IDLE;
            end
            S_ISSUE:      w_state_nxt = S_WAIT_VALID;
            S_WAIT_VALID: w_state_nxt = w_done ? S_RESULT : S_WAIT_VALID;
            S_RESULT:     w_state_nxt = res_ready ? S_IDLE : S_RESULT;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    // registered SET strobe/job, result capture, tags and stray detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_tag     <= '0;
            r_set_en        <= 1'b0;
            r_job           <= '0;
            r_res_valid     <= 1'b0;
            r_res_candidate <= '0;
            r_res_tag       <= '0;
            r_res_err       <= 1'b0;
            r_stray         <= 1'b0;
        end else begin
            r_set_en <= w_pop;
            if (w_pop) begin
                r_job       <= w_head;
                r_res_tag   <= r_issue_tag;
                r_issue_tag <= r_issue_tag + TAG_W'(1);
            end
            if (w_done) begin
                r_res_valid     <= 1'b1;
                r_res_candidate <= set_valid ? set_candidate : 8'h00;
                r_res_err       <= !set_valid;
            end
            if (r_state == S_RESULT && res_ready) begin
                r_res_valid <= 1'b0;
                r_res_err   <= 1'b0;
            end
            if (set_valid && r_state != S_WAIT_VALID) r_stray <= 1'b1;
        end
    end

    assign in_ready      = !w_full;
    assign set_en        = r_set_en;
    assign set_central   = r_job.central;
    assign set_radius    = r_job.radius;
    assign set_mode      = r_job.mode;
    assign res_valid     = r_res_valid;
    assign res_candidate = r_res_candidate;
    assign res_tag       = r_res_tag;
    assign res_err       = r_res_err;
    assign stray_valid   = r_stray;

endmodule

// File: tb/tb_set_job_dispatcher.sv
// tb_set_job_dispatcher: randomized scoreboard bench with a behavioural SET responder
module tb_set_job_dispatcher;
    import set_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int WDOG  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [23:0]      in_central = '0;
    logic [11:0]      in_radius = '0;
    logic [1:0]       in_mode = '0;
    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_busy = 1'b0;
    logic             set_valid = 1'b0;
    logic [7:0]       set_candidate = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [7:0]       res_candidate;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic             stray_valid;

    set_job_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_central(in_central), .in_radius(in_radius), .in_mode(in_mode),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
        .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
        .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
        .res_tag(res_tag), .res_err(res_err), .stray_valid(stray_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       cand;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    set_job_t   q_job[$];
    exp_t       q_res[$];
    int         checks = 0;
    int         errors = 0;
    int         seq = 0;
    bit         set_auto = 1'b1;
    bit         use_fixed = 1'b0;
    bit         rand_ready = 1'b0;
    bit         rand_busy = 1'b0;
    bit         prev_en = 1'b0;
    logic [7:0] fixed_cand = '0;
    set_job_t   mon_j;
    exp_t       mon_e;
    set_job_t   mdl_j;
    logic [7:0] mdl_c;
    int         mdl_lat;

    // the SET stand-in reports a count derived from the job it was handed
    function automatic logic [7:0] cand_of(input set_job_t j);
        return j.central[7:0] + j.central[15:8] + j.central[23:16] + j.radius[7:0]
             + {4'h0, j.radius[11:8]} + {6'h0, j.mode};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic set_job_t rand_job();
        set_job_t j;
        j.central = 24'($urandom());
        j.radius  = 12'($urandom());
        j.mode    = 2'($urandom());
        return j;
    endfunction

    // offers a job until accepted; the scoreboard records what SET and the host must see
    task automatic push_job(input set_job_t j, input bit exp_wdog, output int cyc);
        bit acc;
        exp_t e;
        acc = 1'b0;
        cyc = 0;
        in_central = j.central;
        in_radius  = j.radius;
        in_mode    = j.mode;
        in_valid   = 1'b1;
        while (!acc && cyc < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (!acc) fail("push_accept");
        else begin
            e.cand = exp_wdog ? 8'h00 : (use_fixed ? fixed_cand : cand_of(j));
            e.tag  = TAG_W'(seq);
            e.err  = exp_wdog;
            q_job.push_back(j);
            q_res.push_back(e);
            seq++;
        end
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) fail("wait_res");
    endtask

    task automatic wait_en(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!set_en && n < 50);
        if (!set_en) fail("wait_set_en");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_res.size() != 0 || q_job.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (q_res.size() != 0 || q_job.size() != 0) fail("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // SET responder: after each strobe, one set_valid pulse 1..4 cycles later
    initial begin
        forever begin
            @(negedge clk);
            if (rst && set_en && set_auto) begin
                mdl_j.central = set_central;
                mdl_j.radius  = set_radius;
                mdl_j.mode    = set_mode;
                mdl_c   = use_fixed ? fixed_cand : cand_of(mdl_j);
                mdl_lat = $urandom_range(1, 4);
                repeat (mdl_lat) @(posedge clk);
                #1;
                set_valid     = 1'b1;
                set_candidate = mdl_c;
                @(posedge clk);
                #1;
                set_valid = 1'b0;
            end
        end
    end

    // random downstream backpressure and SET busy when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) res_ready = 1'($urandom_range(0, 1));
            if (rand_busy) set_busy = ($urandom_range(0, 3) == 0);
        end
    end

    // monitor: issue order/contents on set_en, results on each accepted handshake
    always @(negedge clk) begin
        if (rst) begin
            if (set_en) begin
                chk("set_en_pulse", 32'(prev_en), 0);
                if (q_job.size() == 0) fail("issue_unexpected");
                else begin
                    mon_j = q_job.pop_front();
                    chk("set_central", 32'(set_central), 32'(mon_j.central));
                    chk("set_radius", 32'(set_radius), 32'(mon_j.radius));
                    chk("set_mode", 32'(set_mode), 32'(mon_j.mode));
                end
            end
            prev_en = set_en;
            if (res_valid && res_ready) begin
                if (q_res.size() == 0) fail("res_unexpected");
                else begin
                    mon_e = q_res.pop_front();
                    chk("res_candidate", 32'(res_candidate), 32'(mon_e.cand));
                    chk("res_tag", 32'(res_tag), 32'(mon_e.tag));
                    chk("res_err", 32'(res_err), 32'(mon_e.err));
                end
            end
        end else prev_en = 1'b0;
    end

    initial begin
        #300000;
        fail("global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int n;
        int cyc;
        int found;
        logic [7:0] c0;
        logic [TAG_W-1:0] t0;
        set_job_t j;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_set_en", 32'(set_en), 0);
        chk("rst_set_central", 32'(set_central), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_candidate", 32'(res_candidate), 0);
        chk("rst_res_tag", 32'(res_tag), 0);
        chk("rst_res_err", 32'(res_err), 0);
        chk("rst_stray", 32'(stray_valid), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single job, fixed count, latency and one-cycle strobe
        res_ready  = 1'b1;
        use_fixed  = 1'b1;
        fixed_cand = 8'd6;
        j = '{central: 24'h456788, radius: 12'h333, mode: MODE_INTER};
        push_job(j, 1'b0, cyc);
        @(negedge clk) chk("t1_en_early", 32'(set_en), 0);
        @(negedge clk) chk("t1_en", 32'(set_en), 1);
        @(negedge clk) chk("t1_en_drop", 32'(set_en), 0);
        wait_res(n);
        chk("t1_cand", 32'(res_candidate), 6);
        chk("t1_tag", 32'(res_tag), 0);
        drain();
        use_fixed = 1'b0;

        // fill the FIFO while SET is busy; fifth job waits for the first issue
        set_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push_job(rand_job(), 1'b0, cyc);
            chk("t2_accept_now", 32'(cyc), 1);
        end
        fork
            push_job(rand_job(), 1'b0, cyc);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t2_full", 32'(in_ready), 0);
                end
                @(posedge clk);
                #1;
                set_busy = 1'b0;
            end
        join
        chk("t2_fifth_waited", 32'(cyc > 3), 1);
        drain();

        // result backpressure holds everything still
        res_ready = 1'b0;
        push_job(rand_job(), 1'b0, cyc);
        push_job(rand_job(), 1'b0, cyc);
        wait_res(n);
        c0 = res_candidate;
        t0 = res_tag;
        repeat (20) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(res_valid), 1);
            chk("t3_hold_cand", 32'(res_candidate), 32'(c0));
            chk("t3_hold_tag", 32'(res_tag), 32'(t0));
            chk("t3_no_issue", 32'(set_en), 0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        found = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (set_en && found < 0) found = i;
        end
        chk("t3_next_en", 32'(found >= 0 && found <= 2), 1);
        drain();

        // busy stall in IDLE and a stray set_valid
        set_busy = 1'b1;
        push_job(rand_job(), 1'b0, cyc);
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall", 32'(set_en), 0);
        end
        @(posedge clk);
        #1;
        set_valid = 1'b1;
        @(posedge clk);
        #1;
        set_valid = 1'b0;
        @(negedge clk) chk("t4_stray", 32'(stray_valid), 1);
        @(posedge clk);
        #1;
        set_busy = 1'b0;
        @(negedge clk) chk("t4_en_wait", 32'(set_en), 0);
        @(negedge clk) chk("t4_en", 32'(set_en), 1);
        drain();
        chk("t4_stray_sticky", 32'(stray_valid), 1);

`ifdef SET_WDOG_EN
        // SET never answers: the watchdog produces an error result
        set_auto = 1'b0;
        push_job(rand_job(), 1'b1, cyc);
        wait_en(n);
        wait_res(n);
        chk("t6_wdog_cycles", 32'(n >= WDOG && n <= WDOG + 2), 1);
        chk("t6_cand", 32'(res_candidate), 0);
        chk("t6_err", 32'(res_err), 1);
        drain();
        chk("t6_err_clear", 32'(res_err), 0);
        set_auto = 1'b1;
`endif

        // reset in the middle of a job abandons it
        set_auto = 1'b0;
        push_job(rand_job(), 1'b0, cyc);
        wait_en(n);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_set_en", 32'(set_en), 0);
        chk("mid_rst_central", 32'(set_central), 0);
        chk("mid_rst_radius", 32'(set_radius), 0);
        chk("mid_rst_mode", 32'(set_mode), 0);
        chk("mid_rst_res_valid", 32'(res_valid), 0);
        chk("mid_rst_cand", 32'(res_candidate), 0);
        chk("mid_rst_tag", 32'(res_tag), 0);
        chk("mid_rst_err", 32'(res_err), 0);
        chk("mid_rst_stray", 32'(stray_valid), 0);
        q_job.delete();
        q_res.delete();
        seq = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_auto = 1'b1;
        @(posedge clk);
        #1;

        // random traffic long enough to wrap the tag
        rand_ready = 1'b1;
        rand_busy  = 1'b1;
        for (int i = 0; i < 70; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            push_job(rand_job(), 1'b0, cyc);
        end
        rand_busy  = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        set_busy  = 1'b0;
        res_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
